// File: rtl/alu_pipe_pkg.sv
// ---------------------------------------------------------------------------
// alu_pipe_pkg : shared width and opcode definitions for the pipelined ALU
// Revision     : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package alu_pipe_pkg;

  localparam int DATASIZE = 8;
  localparam int OPCODE_W = 3;

  localparam logic [OPCODE_W-1:0] ALU_NAND = 3'd0;
  localparam logic [OPCODE_W-1:0] ALU_ADD  = 3'd1;
  localparam logic [OPCODE_W-1:0] ALU_ADC  = 3'd2;
  localparam logic [OPCODE_W-1:0] ALU_SUB  = 3'd3;
  localparam logic [OPCODE_W-1:0] ALU_AND  = 3'd4;
  localparam logic [OPCODE_W-1:0] ALU_OR   = 3'd5;
  localparam logic [OPCODE_W-1:0] ALU_XOR  = 3'd6;
  localparam logic [OPCODE_W-1:0] ALU_SHL  = 3'd7;

  // Ops whose carry output is remembered for a following ADC.
  function automatic logic writes_cflag(input logic [OPCODE_W-1:0] op);
    return (op == ALU_ADD) || (op == ALU_ADC) || (op == ALU_SUB) || (op == ALU_SHL);
  endfunction

endpackage

`default_nettype wire

// File: rtl/alu_core.sv
// ---------------------------------------------------------------------------
// alu_core : combinational eight-operation ALU with carry and signed overflow
// Revision : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module alu_core
  import alu_pipe_pkg::*;
#(
  parameter int DW  = DATASIZE,
  parameter int OPW = OPCODE_W
) (
  input  logic [DW-1:0]  a,
  input  logic [DW-1:0]  b,
  input  logic [OPW-1:0] op,
  input  logic           cin,
  output logic [DW-1:0]  z,
  output logic           carry,
  output logic           ovf
);

  logic [DW:0] sum;

  always_comb begin
    sum   = '0;
    z     = '0;
    carry = 1'b0;
    ovf   = 1'b0;
    case (op)
      ALU_NAND: z = ~(a & b);
      ALU_ADD: begin
        sum        = {1'b0, a} + {1'b0, b};
        {carry, z} = sum;
        ovf        = (a[DW-1] == b[DW-1]) && (z[DW-1] != a[DW-1]);
      end
      ALU_ADC: begin
        sum        = {1'b0, a} + {1'b0, b} + {{DW{1'b0}}, cin};
        {carry, z} = sum;
        ovf        = (a[DW-1] == b[DW-1]) && (z[DW-1] != a[DW-1]);
      end
      ALU_SUB: begin
        // carry out of a + ~b + 1 is the "no borrow" indication
        sum        = {1'b0, a} + {1'b0, ~b} + {{DW{1'b0}}, 1'b1};
        {carry, z} = sum;
        ovf        = (a[DW-1] != b[DW-1]) && (z[DW-1] != a[DW-1]);
      end
      ALU_AND: z = a & b;
      ALU_OR:  z = a | b;
      ALU_XOR: z = a ^ b;
      ALU_SHL: begin
        z     = {a[DW-2:0], 1'b0};
        carry = a[DW-1];
      end
      default: z = '0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/alu_pipe.sv
// ---------------------------------------------------------------------------
// alu_pipe : two-stage valid/ready pipelined ALU with persistent carry flag
// Revision : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module alu_pipe
  import alu_pipe_pkg::*;
#(
  parameter int DW  = DATASIZE,
  parameter int OPW = OPCODE_W
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [DW-1:0]  a,
  input  logic [DW-1:0]  b,
  input  logic [OPW-1:0] op,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [DW-1:0]  z,
  output logic           carry,
  output logic           zero,
  output logic           neg,
  output logic           ovf
);

  logic           a_valid;
  logic [DW-1:0]  a_q;
  logic [DW-1:0]  b_q;
  logic [OPW-1:0] op_q;
  logic           cflag;

  logic           adv_b;
  logic           take_a;
  logic           move_b;
  logic [DW-1:0]  core_z;
  logic           core_carry;
  logic           core_ovf;

  assign adv_b    = ~out_valid | out_ready;
  assign in_ready = ~a_valid | adv_b;
  assign take_a   = in_valid & in_ready;
  assign move_b   = a_valid & adv_b;

  alu_core #(
    .DW  (DW),
    .OPW (OPW)
  ) u_core (
    .a     (a_q),
    .b     (b_q),
    .op    (op_q),
    .cin   (cflag),
    .z     (core_z),
    .carry (core_carry),
    .ovf   (core_ovf)
  );

  // Stage A: operand capture. Draining and refilling in one cycle leaves a_valid set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_valid <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
    end else begin
      if (take_a) begin
        a_valid <= 1'b1;
        a_q     <= a;
        b_q     <= b;
        op_q    <= op;
      end else if (move_b) begin
        a_valid <= 1'b0;
      end
    end
  end

  // Stage B: result registers hold while the consumer stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      z         <= '0;
      carry     <= 1'b0;
      zero      <= 1'b0;
      neg       <= 1'b0;
      ovf       <= 1'b0;
      cflag     <= 1'b0;
    end else begin
      if (move_b) begin
        out_valid <= 1'b1;
        z         <= core_z;
        carry     <= core_carry;
        zero      <= ~|core_z;
        neg       <= core_z[DW-1];
        ovf       <= core_ovf;
        if (writes_cflag(op_q)) begin
          cflag <= core_carry;
        end
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire
